// File: rtl/bidir_shift_sequencer.sv
// Shares one external WIDTH-stage bidirectional shift register between two
// requesters. Each transfer shifts a new word in serially while capturing the
// old contents from the register's serial output, then reports the old word.
module bidir_shift_sequencer #(
    parameter int   WIDTH     = 8,
    parameter logic IDLE_FILL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic             a_dir,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic             b_dir,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             reg_d,
    output logic             reg_shift,
    input  logic             reg_q,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_owner,
    output logic             busy
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic             prio;       // 0 = A has the tie, 1 = B has the tie
    logic             dir_r, owner_r;
    logic [WIDTH-1:0] tx_buf, rx_buf, rx_next;
    logic             grant_b, accept, last;
    logic [WIDTH-1:0] sel_data;
    logic             sel_dir;
    logic [CW-1:0]    idx, nidx;

    // Round-robin grant and the combinational ready handshake
    always_comb begin
        grant_b  = b_valid && (!a_valid || prio);
        a_ready  = (state == IDLE) && a_valid && !grant_b;
        b_ready  = (state == IDLE) && grant_b;
        accept   = a_ready || b_ready;
        sel_data = b_ready ? b_data : a_data;
        sel_dir  = b_ready ? b_dir : a_dir;
    end

    // Bit index driven this cycle, the one for the next cycle, and the
    // capture buffer with this cycle's reg_q merged in
    always_comb begin
        last    = (count == CW'(WIDTH - 1));
        idx     = dir_r ? count : CW'(WIDTH - 1) - count;
        nidx    = dir_r ? count + CW'(1) : CW'(WIDTH - 2) - count;
        rx_next = rx_buf;
        rx_next[idx] = reg_q;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, drive/capture one bit per SHIFT cycle,
    // publish the captured word on the last edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            prio      <= 1'b0;
            dir_r     <= 1'b1;
            owner_r   <= 1'b0;
            tx_buf    <= '0;
            rx_buf    <= '0;
            reg_d     <= IDLE_FILL;
            reg_shift <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_owner  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_buf    <= sel_data;
                        dir_r     <= sel_dir;
                        owner_r   <= b_ready;
                        prio      <= !b_ready;
                        count     <= '0;
                        reg_shift <= sel_dir;
                        // First bit is presented in the first SHIFT cycle
                        reg_d     <= sel_dir ? sel_data[0] : sel_data[WIDTH-1];
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    rx_buf <= rx_next;
                    if (last) begin
                        count    <= '0;
                        reg_d    <= IDLE_FILL;
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                        rx_owner <= owner_r;
                    end else begin
                        count <= count + CW'(1);
                        reg_d <= tx_buf[nidx];
                    end
                end
                DONE: busy <= 1'b0;
                default: busy <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_bidir_shift_sequencer.sv
// Directed bench for bidir_shift_sequencer with a behavioural model of the
// external bidirectional shift register hanging off reg_d/reg_q.
module tb_bidir_shift_sequencer;
    logic       clk = 0, rst = 1;
    logic       a_valid = 0, a_dir = 0, b_valid = 0, b_dir = 0;
    logic [7:0] a_data = 0, b_data = 0;
    logic       a_ready, b_ready, reg_d, reg_shift, reg_q;
    logic [7:0] rx_data;
    logic       rx_valid, rx_owner, busy;

    int total = 0, bad = 0;

    bidir_shift_sequencer #(.WIDTH(8), .IDLE_FILL(1'b0)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_dir(a_dir), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_dir(b_dir), .b_data(b_data), .b_ready(b_ready),
        .reg_d(reg_d), .reg_shift(reg_shift), .reg_q(reg_q),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_owner(rx_owner), .busy(busy)
    );

    always #5 clk = ~clk;

    // External register model: shift=1 moves toward bit 0 (out at bit 0,
    // in at bit 7); shift=0 moves toward bit 7 (out at bit 7, in at bit 0)
    logic [7:0] mreg = 0;
    logic       load_en = 0;
    logic [7:0] load_val = 0;
    always @(posedge clk) begin
        if (load_en)               mreg <= load_val;
        else if (busy && !rx_valid) mreg <= reg_shift ? {reg_d, mreg[7:1]} : {mreg[6:0], reg_d};
    end
    assign reg_q = reg_shift ? mreg[0] : mreg[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] v);
        @(negedge clk); load_en = 1; load_val = v;
        @(negedge clk); load_en = 0;
    endtask

    // Called at a negedge: raise a request and wait (bounded) until accepted;
    // returns just after the accept edge with the request dropped
    task automatic request(input logic own, input logic dir, input logic [7:0] data);
        bit got = 0;
        if (own) begin b_valid = 1; b_dir = dir; b_data = data; end
        else     begin a_valid = 1; a_dir = dir; a_data = data; end
        for (int i = 0; i < 30; i++) begin
            #1;
            if (own ? b_ready : a_ready) begin got = 1; break; end
            @(negedge clk);
        end
        check(own ? "accept_b" : "accept_a", got, 1);
        @(posedge clk); #1;
        if (own) b_valid = 0; else a_valid = 0;
    endtask

    // Full transfer returning the completion word, bounded wait
    task automatic xfer(input logic own, input logic dir, input logic [7:0] data,
                        output logic [7:0] rx);
        bit got = 0;
        @(negedge clk);
        request(own, dir, data);
        rx = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_valid) begin got = 1; rx = rx_data; break; end
        end
        check("xfer_done", got, 1);
        @(negedge clk);
    endtask

    typedef struct {
        logic       own;
        logic       dir;
        logic [7:0] data;
        logic [7:0] preload;
        logic [7:0] seq;   // seq[k] = reg_d in SHIFT cycle k
    } vec_t;
    vec_t vecs[4];

    initial begin
        logic [7:0] seq_got, rx;
        bit         dir_ok, rdy_ok;
        int         acc_cyc[8], acc_own[8], rx_own[8], n_acc, n_rx;
        logic [7:0] rx_words[8];

        vecs[0] = '{own: 0, dir: 1, data: 8'hA5, preload: 8'h3C, seq: 8'hA5};
        vecs[1] = '{own: 1, dir: 0, data: 8'h81, preload: 8'h5A, seq: 8'h81};
        vecs[2] = '{own: 0, dir: 0, data: 8'h0F, preload: 8'hF0, seq: 8'hF0};
        vecs[3] = '{own: 1, dir: 1, data: 8'hC3, preload: 8'h96, seq: 8'hC3};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_reg_d", reg_d, 0);
        check("rst_reg_shift", reg_shift, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        rst = 0;

        // Table-driven single exchanges
        for (int v = 0; v < 4; v++) begin
            preload(vecs[v].preload);
            @(negedge clk);
            request(vecs[v].own, vecs[v].dir, vecs[v].data);
            dir_ok = 1; rdy_ok = 1; seq_got = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                seq_got[k] = reg_d;
                if (reg_shift !== vecs[v].dir || busy !== 1'b1) dir_ok = 0;
                if (a_ready || b_ready || rx_valid) rdy_ok = 0;
            end
            check("vec_reg_d_seq", seq_got, vecs[v].seq);
            check("vec_shift_busy", dir_ok, 1);
            check("vec_quiet_shift", rdy_ok, 1);
            @(negedge clk);
            check("vec_rx_valid_lat", rx_valid, 1);
            check("vec_rx_data", rx_data, vecs[v].preload);
            check("vec_rx_owner", rx_owner, vecs[v].own);
            check("vec_done_fill", reg_d, 0);
            @(negedge clk);
            check("vec_rx_pulse", rx_valid, 0);
            check("vec_idle_busy", busy, 0);
            check("vec_reg_holds", mreg, vecs[v].data);
            check("vec_rx_hold", rx_data, vecs[v].preload);
        end

        // B asks during A's transfer; served in the first IDLE cycle
        preload(8'h55);
        @(negedge clk);
        request(0, 1, 8'h0F);
        rdy_ok = 1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) begin b_valid = 1; b_dir = 1; b_data = 8'hF0; end
            #1;
            if (b_ready) rdy_ok = 0;
            if (k == 8) check("mid_a_rx", rx_data, 8'h55);
        end
        check("mid_b_held_off", rdy_ok, 1);
        @(negedge clk); #1;
        check("mid_b_accept_idle", b_ready, 1);
        @(posedge clk); #1; b_valid = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 8) begin
                check("mid_b_rx_valid", rx_valid, 1);
                check("mid_b_rx_data", rx_data, 8'h0F);
                check("mid_b_rx_owner", rx_owner, 1);
            end
        end

        // Back-to-back chaining returns the previous word
        preload(8'h00);
        xfer(0, 1, 8'h11, rx);
        check("chain_first", rx, 8'h00);
        xfer(0, 0, 8'h22, rx);
        check("chain_second", rx, 8'h11);

        // Reset in the middle of a transfer
        preload(8'h77);
        @(negedge clk);
        request(0, 0, 8'h99);
        repeat (3) @(negedge clk);
        rst = 1; #1;
        check("mrst_busy", busy, 0);
        check("mrst_reg_shift", reg_shift, 1);
        check("mrst_reg_d", reg_d, 0);
        check("mrst_rx_data", rx_data, 0);
        @(negedge clk); rst = 0;
        rdy_ok = 1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (rx_valid || busy) rdy_ok = 0;
        end
        check("mrst_no_rx", rdy_ok, 1);

        // Contention right after reset: A wins the first tie, then alternate
        preload(8'hE7);
        @(negedge clk);
        a_valid = 1; a_dir = 1; a_data = 8'h3A;
        b_valid = 1; b_dir = 0; b_data = 8'hC5;
        n_acc = 0; n_rx = 0; rdy_ok = 1;
        for (int c = 0; c < 45; c++) begin
            #1;
            if (a_ready && b_ready) rdy_ok = 0;
            if ((a_ready || b_ready) && n_acc < 8) begin
                acc_cyc[n_acc] = c; acc_own[n_acc] = b_ready; n_acc++;
            end
            if (rx_valid && n_rx < 8) begin
                rx_own[n_rx] = rx_owner; rx_words[n_rx] = rx_data; n_rx++;
            end
            @(negedge clk);
        end
        a_valid = 0; b_valid = 0;
        check("cont_one_ready", rdy_ok, 1);
        check("cont_accepts", n_acc >= 4, 1);
        check("cont_rx_count", n_rx >= 3, 1);
        if (n_acc >= 4 && n_rx >= 3) begin
            check("cont_first_cyc", acc_cyc[0], 0);
            for (int i = 0; i < 4; i++) check("cont_owner", acc_own[i], i % 2);
            for (int i = 1; i < 4; i++) check("cont_period", acc_cyc[i] - acc_cyc[i-1], 10);
            for (int i = 0; i < 3; i++) check("cont_rx_owner", rx_own[i], i % 2);
            check("cont_rx0", rx_words[0], 8'hE7);
            check("cont_rx1", rx_words[1], 8'h3A);
            check("cont_rx2", rx_words[2], 8'hC5);
        end
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
